// File: rtl/bist_vector_harness.sv
// On-chip stimulus/response harness: drives counter or Galois-LFSR vectors into a
// netlist under test and compacts its responses into a MISR signature checked at end of run.
module bist_vector_harness #(
  parameter int unsigned      IN_W           = 6,
  parameter int unsigned      OUT_W          = 16,
  parameter int unsigned      NUM_VECTORS    = 64,
  parameter int unsigned      SETTLE_CYCLES  = 1,
  parameter int unsigned      DUT_RST_CYCLES = 2,
  parameter int unsigned      MODE           = 0,
  parameter logic [IN_W-1:0]  LFSR_POLY      = IN_W'(6'h30),
  parameter logic [IN_W-1:0]  LFSR_SEED      = IN_W'(1),
  parameter logic [OUT_W-1:0] MISR_POLY      = OUT_W'(16'h002D)
) (
  input  logic             bertaClock,
  input  logic             global_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] expected_sig,
  input  logic [OUT_W-1:0] resp_in,
  output logic [IN_W-1:0]  stim_out,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      vec_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned VC_W  = 17;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0]  SEED_EFF    = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [IN_W-1:0]  GEN_INIT    = (MODE != 0) ? SEED_EFF : '0;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(DUT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VC_W-1:0]  NUM_VC      = VC_W'(NUM_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  gen;
  logic [CNT_W-1:0] phase_cnt;
  logic [VC_W-1:0]  vc;

  logic [IN_W-1:0]  gen_next_c;
  logic [OUT_W-1:0] misr_next_c;
  logic [VC_W-1:0]  vc_next_c;

  // Next generator value: plain counter or right-shifting Galois LFSR.
  always_comb begin
    gen_next_c = gen + IN_W'(1);
    if (MODE != 0) begin
      gen_next_c = gen[0] ? ((gen >> 1) ^ LFSR_POLY) : (gen >> 1);
    end
  end

  assign misr_next_c = {signature[OUT_W-2:0], 1'b0}
                     ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                     ^ resp_in;
  assign vc_next_c   = vc + VC_W'(1);
  assign vec_count   = vc[15:0];

  always_ff @(posedge bertaClock) begin
    if (global_reset) begin
      state     <= S_IDLE;
      stim_out  <= '0;
      dut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      vc        <= '0;
      gen       <= GEN_INIT;
      phase_cnt <= '0;
    end else if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      // Signature and count stay frozen so an aborted run can be inspected.
      state     <= S_IDLE;
      dut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state     <= S_DUT_RST;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            dut_reset <= 1'b1;
            signature <= '0;
            vc        <= '0;
            stim_out  <= '0;
            gen       <= GEN_INIT;
            phase_cnt <= '0;
          end
        end
        S_DUT_RST: begin
          if (phase_cnt == RST_LAST) begin
            dut_reset <= 1'b0;
            state     <= S_APPLY;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        S_APPLY: begin
          stim_out  <= gen;
          gen       <= gen_next_c;
          phase_cnt <= '0;
          state     <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_CAPTURE;
        end
        S_SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          signature <= misr_next_c;
          vc        <= vc_next_c;
          if (vc_next_c == NUM_VC) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_next_c == expected_sig);
          end else begin
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_vector_harness.sv
// Randomised bench for bist_vector_harness: three configurations checked against a
// behavioural model of the vector sequence and MISR compaction.
module tb_bist_vector_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A: counter mode, identity/timing configuration
  logic        rst_a, start_a, abort_a, use_id_a;
  logic [3:0]  exp_a, resp_a, sig_a;
  logic [1:0]  stim_a;
  logic        dr_a, busy_a, done_a, pass_a;
  logic [15:0] vc_a;
  logic [31:0] lut_a [16];
  assign resp_a = use_id_a ? {2'b00, stim_a} : lut_a[{2'b00, stim_a}][3:0];

  bist_vector_harness #(
    .IN_W(2), .OUT_W(4), .NUM_VECTORS(4), .SETTLE_CYCLES(1), .DUT_RST_CYCLES(2),
    .MODE(0), .LFSR_POLY(2'h3), .LFSR_SEED(2'h1), .MISR_POLY(4'h3)
  ) u_a (
    .bertaClock(clk), .global_reset(rst_a), .start(start_a), .abort(abort_a),
    .expected_sig(exp_a), .resp_in(resp_a), .stim_out(stim_a), .dut_reset(dr_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .vec_count(vc_a)
  );

  // B: LFSR mode, long run with zero settle
  logic        rst_b, start_b, abort_b;
  logic [7:0]  exp_b, resp_b, sig_b;
  logic [3:0]  stim_b;
  logic        dr_b, busy_b, done_b, pass_b;
  logic [15:0] vc_b;
  logic [31:0] lut_b [16];
  assign resp_b = lut_b[stim_b][7:0];

  bist_vector_harness #(
    .IN_W(4), .OUT_W(8), .NUM_VECTORS(64), .SETTLE_CYCLES(0), .DUT_RST_CYCLES(1),
    .MODE(1), .LFSR_POLY(4'hC), .LFSR_SEED(4'h1), .MISR_POLY(8'h1D)
  ) u_b (
    .bertaClock(clk), .global_reset(rst_b), .start(start_b), .abort(abort_b),
    .expected_sig(exp_b), .resp_in(resp_b), .stim_out(stim_b), .dut_reset(dr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .vec_count(vc_b)
  );

  // C: LFSR mode with zero seed; used for reset/abort/ignore scenarios
  logic        rst_c, start_c, abort_c;
  logic [5:0]  exp_c, resp_c, sig_c;
  logic [3:0]  stim_c;
  logic        dr_c, busy_c, done_c, pass_c;
  logic [15:0] vc_c;
  logic [31:0] lut_c [16];
  assign resp_c = lut_c[stim_c][5:0];

  bist_vector_harness #(
    .IN_W(4), .OUT_W(6), .NUM_VECTORS(9), .SETTLE_CYCLES(2), .DUT_RST_CYCLES(3),
    .MODE(1), .LFSR_POLY(4'hC), .LFSR_SEED(4'h0), .MISR_POLY(6'h21)
  ) u_c (
    .bertaClock(clk), .global_reset(rst_c), .start(start_c), .abort(abort_c),
    .expected_sig(exp_c), .resp_in(resp_c), .stim_out(stim_c), .dut_reset(dr_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .vec_count(vc_c)
  );

  // Monitors: run latency, dut_reset length, and vector/signature at each capture
  int unsigned tb_a, td_a, drc_a, tb_b, td_b, drc_b, tb_c, td_c, drc_c;
  logic        busy_a_q = 1'b0, done_a_q = 1'b0, busy_b_q = 1'b0, done_b_q = 1'b0;
  logic        busy_c_q = 1'b0, done_c_q = 1'b0;
  logic [15:0] vc_a_q = '0, vc_b_q = '0, vc_c_q = '0;
  logic [31:0] stimq_a[$], sigq_a[$], stimq_b[$], sigq_b[$], stimq_c[$], sigq_c[$];

  always @(negedge clk) begin
    if (busy_a && !busy_a_q) begin tb_a = cyc; drc_a = 0; stimq_a.delete(); sigq_a.delete(); end
    if (dr_a) drc_a++;
    if (done_a && !done_a_q) td_a = cyc;
    if (vc_a != vc_a_q && vc_a != 16'd0) begin stimq_a.push_back(32'(stim_a)); sigq_a.push_back(32'(sig_a)); end
    busy_a_q = busy_a; done_a_q = done_a; vc_a_q = vc_a;

    if (busy_b && !busy_b_q) begin tb_b = cyc; drc_b = 0; stimq_b.delete(); sigq_b.delete(); end
    if (dr_b) drc_b++;
    if (done_b && !done_b_q) td_b = cyc;
    if (vc_b != vc_b_q && vc_b != 16'd0) begin stimq_b.push_back(32'(stim_b)); sigq_b.push_back(32'(sig_b)); end
    busy_b_q = busy_b; done_b_q = done_b; vc_b_q = vc_b;

    if (busy_c && !busy_c_q) begin tb_c = cyc; drc_c = 0; stimq_c.delete(); sigq_c.delete(); end
    if (dr_c) drc_c++;
    if (done_c && !done_c_q) td_c = cyc;
    if (vc_c != vc_c_q && vc_c != 16'd0) begin stimq_c.push_back(32'(stim_c)); sigq_c.push_back(32'(sig_c)); end
    busy_c_q = busy_c; done_c_q = done_c; vc_c_q = vc_c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // k-th vector of a run (k counts from 0)
  function automatic logic [31:0] vec_k(input bit lfsr, input int w, input logic [31:0] poly,
                                        input logic [31:0] seed, input int k);
    logic [31:0] x;
    if (!lfsr) return 32'(k % (1 << w));
    x = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < k; i++) x = (x % 2 == 32'd1) ? ((x / 2) ^ poly) : (x / 2);
    return x;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r,
                                            input logic [31:0] poly, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return ((s * 2) & m) ^ ((((s >> (w - 1)) & 32'd1) != 32'd0) ? poly : 32'd0) ^ r;
  endfunction

  // Signature after the first 'upto' captures of a run
  function automatic logic [31:0] predict_sig(input bit lfsr, input int iw, input logic [31:0] lpoly,
      input logic [31:0] seed, input int ow, input logic [31:0] mpoly, input logic [31:0] rl[16],
      input bit ident, input int upto);
    logic [31:0] s, v, r;
    s = 32'd0;
    for (int k = 0; k < upto; k++) begin
      v = vec_k(lfsr, iw, lpoly, seed, k);
      r = ident ? v : rl[v[3:0]];
      s = misr_step(s, r, mpoly, ow);
    end
    return s;
  endfunction

  task automatic check_run(input string tag, input logic [31:0] sq[$], input logic [31:0] gq[$],
      input bit lfsr, input int iw, input logic [31:0] lpoly, input logic [31:0] seed,
      input int ow, input logic [31:0] mpoly, input logic [31:0] rl[16], input bit ident, input int n);
    check({tag, "_ncap"}, 32'(sq.size()), 32'(n));
    for (int k = 0; k < n && k < sq.size(); k++) begin
      check($sformatf("%s_vec%0d", tag, k), sq[k], vec_k(lfsr, iw, lpoly, seed, k));
      check($sformatf("%s_sig%0d", tag, k), gq[k],
            predict_sig(lfsr, iw, lpoly, seed, ow, mpoly, rl, ident, k + 1));
    end
  endtask

  task automatic wait_done(input string tag, input int unsigned max_cyc, input int which);
    int unsigned n;
    logic d;
    n = 0;
    d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    while (!d && n < max_cyc) begin
      tick();
      n++;
      d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    end
    check({tag, "_done_seen"}, 32'(d), 32'd1);
  endtask

  task automatic wait_vc_c(input string tag, input logic [15:0] target, input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    while (vc_c != target && n < max_cyc) begin tick(); n++; end
    check({tag, "_vc_seen"}, 32'(vc_c), 32'(target));
  endtask

  logic [31:0] p, sq5;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0; use_id_a = 1'b1;
    for (int i = 0; i < 16; i++) begin lut_a[i] = 32'd0; lut_b[i] = 32'd0; lut_c[i] = 32'd0; end
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    check("a_reset", 32'({busy_a, done_a, pass_a, dr_a, stim_a, sig_a, vc_a}), 32'd0);
    check("b_reset", 32'({busy_b, done_b, pass_b, dr_b, stim_b, sig_b, vc_b}), 32'd0);
    check("c_reset", 32'({busy_c, done_c, pass_c, dr_c, stim_c, sig_c, vc_c}), 32'd0);

    // A1: identity loop, golden 3
    exp_a = 4'h3;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done("a1", 100, 0);
    check_run("a1", stimq_a, sigq_a, 1'b0, 2, 32'h3, 32'h1, 4, 32'h3, lut_a, 1'b1, 4);
    sq5 = {16'd0, sigq_a[0][3:0], sigq_a[1][3:0], sigq_a[2][3:0], sigq_a[3][3:0]};
    check("a1_sig_trace", sq5, 32'h0103);
    check("a1_sig", 32'(sig_a), 32'h3);
    check("a1_pass", 32'(pass_a), 32'd1);
    check("a1_vc", 32'(vc_a), 32'd4);
    check("a1_latency", td_a - tb_a, 32'd14);
    check("a1_dutrst_len", drc_a, 32'd2);

    // A2: wrong golden, restart from DONE
    exp_a = 4'h2;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done("a2", 100, 0);
    check("a2_pass", 32'(pass_a), 32'd0);
    repeat (3) tick();
    check("a2_done_held", 32'({done_a, busy_a}), 32'b10);

    // A3: random response table
    use_id_a = 1'b0;
    for (int i = 0; i < 16; i++) lut_a[i] = $urandom & 32'hF;
    p = predict_sig(1'b0, 2, 32'h3, 32'h1, 4, 32'h3, lut_a, 1'b0, 4);
    exp_a = p[3:0];
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done("a3", 100, 0);
    check_run("a3", stimq_a, sigq_a, 1'b0, 2, 32'h3, 32'h1, 4, 32'h3, lut_a, 1'b0, 4);
    check("a3_pass", 32'(pass_a), 32'd1);

    // B1: responses tied to zero
    exp_b = 8'h00;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done("b1", 400, 1);
    check_run("b1", stimq_b, sigq_b, 1'b1, 4, 32'hC, 32'h1, 8, 32'h1D, lut_b, 1'b0, 64);
    sq5 = {12'd0, stimq_b[0][3:0], stimq_b[1][3:0], stimq_b[2][3:0], stimq_b[3][3:0], stimq_b[4][3:0]};
    check("b1_lfsr_head", sq5, 32'h1C63D);
    check("b1_lfsr_vec16", stimq_b[15], 32'h1);
    check("b1_sig", 32'(sig_b), 32'd0);
    check("b1_pass", 32'(pass_b), 32'd1);
    check("b1_vc", 32'(vc_b), 32'd64);
    check("b1_latency", td_b - tb_b, 32'd129);
    check("b1_dutrst_len", drc_b, 32'd1);

    // B2/B3: random responses, matching then mismatching golden
    for (int i = 0; i < 16; i++) lut_b[i] = $urandom & 32'hFF;
    p = predict_sig(1'b1, 4, 32'hC, 32'h1, 8, 32'h1D, lut_b, 1'b0, 64);
    exp_b = p[7:0];
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done("b2", 400, 1);
    check_run("b2", stimq_b, sigq_b, 1'b1, 4, 32'hC, 32'h1, 8, 32'h1D, lut_b, 1'b0, 64);
    check("b2_pass", 32'(pass_b), 32'd1);
    exp_b = p[7:0] ^ 8'h80;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done("b3", 400, 1);
    check("b3_sig", 32'(sig_b), p & 32'hFF);
    check("b3_pass", 32'(pass_b), 32'd0);

    // C1: reset during settle of the fifth vector
    for (int i = 0; i < 16; i++) lut_c[i] = $urandom & 32'h3F;
    p = predict_sig(1'b1, 4, 32'hC, 32'h0, 6, 32'h21, lut_c, 1'b0, 9);
    exp_c = p[5:0];
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_vc_c("c1", 16'd4, 200);
    tick();
    check("c1_vec5", 32'(stim_c), vec_k(1'b1, 4, 32'hC, 32'h0, 4));
    rst_c = 1'b1; tick(); rst_c = 1'b0;
    check("c1_midreset", 32'({busy_c, done_c, pass_c, dr_c, stim_c, sig_c, vc_c}), 32'd0);

    // C2: full run after reset, zero seed
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_done("c2", 200, 2);
    check_run("c2", stimq_c, sigq_c, 1'b1, 4, 32'hC, 32'h0, 6, 32'h21, lut_c, 1'b0, 9);
    check("c2_seed0_first", stimq_c[0], 32'h1);
    check("c2_pass", 32'(pass_c), 32'd1);
    check("c2_vc", 32'(vc_c), 32'd9);
    check("c2_latency", td_c - tb_c, 32'd39);
    check("c2_dutrst_len", drc_c, 32'd3);

    // C3: abort at three captured vectors
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_vc_c("c3", 16'd3, 200);
    abort_c = 1'b1; tick(); abort_c = 1'b0;
    check("c3_abort_flags", 32'({busy_c, done_c, pass_c, dr_c}), 32'd0);
    check("c3_abort_vc", 32'(vc_c), 32'd3);
    check("c3_abort_sig", 32'(sig_c), predict_sig(1'b1, 4, 32'hC, 32'h0, 6, 32'h21, lut_c, 1'b0, 3));
    repeat (4) tick();
    check("c3_frozen", 32'({busy_c, vc_c}), 32'd3);

    // C4: start and abort together in IDLE
    start_c = 1'b1; abort_c = 1'b1; tick(); start_c = 1'b0; abort_c = 1'b0;
    check("c4_stay_idle", 32'({busy_c, dr_c, done_c}), 32'd0);
    repeat (2) tick();
    check("c4_still_idle", 32'({busy_c, dr_c, vc_c}), 32'd3);

    // C5: start pulse during APPLY is ignored
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_vc_c("c5", 16'd2, 200);
    start_c = 1'b1; tick(); start_c = 1'b0;
    wait_done("c5", 200, 2);
    check_run("c5", stimq_c, sigq_c, 1'b1, 4, 32'hC, 32'h0, 6, 32'h21, lut_c, 1'b0, 9);
    check("c5_latency", td_c - tb_c, 32'd39);
    check("c5_vc", 32'(vc_c), 32'd9);
    check("c5_pass", 32'(pass_c), 32'd1);

    // C6: abort in DONE has no effect
    abort_c = 1'b1; tick(); abort_c = 1'b0;
    check("c6_done_kept", 32'({done_c, pass_c, busy_c}), 32'b110);
    check("c6_sig_kept", 32'(sig_c), p & 32'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
